// File: rtl/dadda_mul16_seq.sv
// dadda_mul16_seq: sequential 16x16 unsigned multiplier that reuses one 8x8 Dadda core over four byte products.
// Define DADDA_SEQ_SKIP_ZERO_EN to skip byte products that have a zero operand byte.
module dadda_8 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);
    logic [15:0] col [17];
    logic [15:0] nxt [17];
    int          n   [17];
    int          nn  [17];
    int          d;
    int          k;
    logic [15:0] r0;
    logic [15:0] r1;
    // Columns are bit stacks: bits are pushed in at the LSB end and popped by right shifts.
    always_comb begin
        for (int i = 0; i < 17; i++) begin
            col[i] = '0;
            nxt[i] = '0;
            n[i] = 0;
            nn[i] = 0;
        end
        d = 0;
        k = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) begin
                col[i+j] = {col[i+j][14:0], a[i] & b[j]};
                n[i+j] += 1;
            end
        for (int s = 0; s < 4; s++) begin
            d = s == 0 ? 6 : s == 1 ? 4 : s == 2 ? 3 : 2;
            for (int i = 0; i < 17; i++) begin
                nxt[i] = '0;
                nn[i] = 0;
            end
            for (int i = 0; i < 16; i++) begin
                k = 0;
                for (int t = 0; t < 8; t++) begin
                    if (n[i] - k >= 3 && n[i] - k + nn[i] - d >= 2) begin
                        nxt[i] = {nxt[i][14:0], col[i][0] ^ col[i][1] ^ col[i][2]};
                        nxt[i+1] = {nxt[i+1][14:0], (col[i][0] & col[i][1]) | (col[i][2] & (col[i][0] ^ col[i][1]))};
                        nn[i] += 1;
                        nn[i+1] += 1;
                        col[i] = col[i] >> 3;
                        k += 3;
                    end else if (n[i] - k >= 2 && n[i] - k + nn[i] - d >= 1) begin
                        nxt[i] = {nxt[i][14:0], col[i][0] ^ col[i][1]};
                        nxt[i+1] = {nxt[i+1][14:0], col[i][0] & col[i][1]};
                        nn[i] += 1;
                        nn[i+1] += 1;
                        col[i] = col[i] >> 2;
                        k += 2;
                    end
                end
                for (int j = 0; j < 16; j++)
                    if (j < n[i] - k) begin
                        nxt[i] = {nxt[i][14:0], col[i][0]};
                        col[i] = col[i] >> 1;
                        nn[i] += 1;
                    end
            end
            col = nxt;
            n = nn;
        end
        for (int i = 0; i < 16; i++) begin
            r0[i] = col[i][0];
            r1[i] = col[i][1];
        end
        p = r0 + r1;
    end
endmodule

module dadda_mul16_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Y,
    output logic        busy
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] PP0  = 3'd1;
    localparam logic [2:0] PP1  = 3'd2;
    localparam logic [2:0] PP2  = 3'd3;
    localparam logic [2:0] PP3  = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [31:0] acc_q, acc_d, y_q, y_d;
    logic [7:0]  pa, pb;
    logic [15:0] pp;
    logic [4:0]  sh;
    logic [3:0]  nz_in, nz_q;

    function automatic logic [2:0] first_pp(input logic [3:0] m);
        return m[0] ? PP0 : m[1] ? PP1 : m[2] ? PP2 : m[3] ? PP3 : DONE;
    endfunction

`ifdef DADDA_SEQ_SKIP_ZERO_EN
    function automatic logic [3:0] nz(input logic [15:0] a, input logic [15:0] b);
        return {(|a[15:8]) & (|b[15:8]), (|a[15:8]) & (|b[7:0]), (|a[7:0]) & (|b[15:8]), (|a[7:0]) & (|b[7:0])};
    endfunction
    assign nz_in = nz(A, B);
    assign nz_q  = nz(a_q, b_q);
`else
    assign nz_in = 4'hf;
    assign nz_q  = 4'hf;
`endif

    assign pa = (state_q == PP0 || state_q == PP1) ? a_q[7:0] : a_q[15:8];
    assign pb = (state_q == PP0 || state_q == PP2) ? b_q[7:0] : b_q[15:8];
    assign sh = state_q == PP0 ? 5'd0 : state_q == PP3 ? 5'd16 : 5'd8;

    dadda_8 u_core (.a(pa), .b(pb), .p(pp));

    // The mask drops the current and earlier byte products, leaving the next live one.
    always_comb begin
        state_d = state_q;
        a_d = a_q;
        b_d = b_q;
        acc_d = acc_q;
        y_d = y_q;
        if (state_q == IDLE) begin
            if (in_valid) begin
                a_d = A;
                b_d = B;
                acc_d = '0;
                state_d = first_pp(nz_in);
            end
        end else if (state_q == DONE) begin
            state_d = out_ready ? IDLE : DONE;
        end else begin
            acc_d = acc_q + ({16'd0, pp} << sh);
            state_d = first_pp(nz_q & (4'hf << state_q));
        end
        if (state_d == DONE && state_q != DONE)
            y_d = acc_d;
        if (rst) begin
            state_d = IDLE;
            a_d = '0;
            b_d = '0;
            acc_d = '0;
            y_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        a_q <= a_d;
        b_q <= b_d;
        acc_q <= acc_d;
        y_q <= y_d;
    end

    assign in_ready  = state_q == IDLE && !rst;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign Y         = y_q;
endmodule

// File: tb/tb_dadda_mul16_seq.sv
// tb_dadda_mul16_seq: directed self-checking bench for dadda_mul16_seq.
// Expected latencies follow DADDA_SEQ_SKIP_ZERO_EN when it is defined.
module tb_dadda_mul16_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Y;
    logic        busy;
    int          tests = 0;
    int          fails = 0;

    logic [15:0] va  [7] = '{16'h1234, 16'hFFFF, 16'hABCD, 16'h00FF, 16'h0001, 16'h8000, 16'h0000};
    logic [15:0] vb  [7] = '{16'h5678, 16'hFFFF, 16'h1234, 16'h0100, 16'h0001, 16'h0002, 16'hABCD};
    logic [31:0] ve  [7] = '{32'h06260060, 32'hFFFE0001, 32'h0C374FA4, 32'h0000FF00, 32'h00000001, 32'h00010000, 32'h00000000};
    int          vls [7] = '{5, 5, 5, 2, 2, 2, 1};

    always #5 clk = ~clk;

    dadda_mul16_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
        .out_valid(out_valid), .out_ready(out_ready), .Y(Y), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_mul(input logic [15:0] a, input logic [15:0] b, output logic [31:0] y, output int lat);
        int g = 0;
        while (!in_ready && g < 30) begin
            tick();
            g++;
        end
        A = a;
        B = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        y = Y;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        A = 16'hFFFF;
        B = 16'hFFFF;
        out_ready = 1'b0;
        tick();
        tick();
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        tests++; if (Y !== 32'h0) begin fails++; $display("FAIL reset_y: got %h expected 00000000", Y); end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_basic();
        logic [31:0] y;
        int lat;
        int el;
        for (int i = 0; i < 7; i++) begin
`ifdef DADDA_SEQ_SKIP_ZERO_EN
            el = vls[i];
`else
            el = 5;
`endif
            run_mul(va[i], vb[i], y, lat);
            tests++;
            if (y !== ve[i]) begin fails++; $display("FAIL basic_y[%0d] %h*%h: got %h expected %h", i, va[i], vb[i], y, ve[i]); end
            tests++;
            if (lat !== el) begin fails++; $display("FAIL basic_latency[%0d]: got cycle %0d expected cycle %0d", i, lat, el); end
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] y;
        int lat;
        out_ready = 1'b0;
        run_mul(16'hFFFF, 16'hFFFF, y, lat);
        tests++; if (y !== 32'hFFFE0001) begin fails++; $display("FAIL bp_y: got %h expected fffe0001", y); end
        in_valid = 1'b1;
        A = 16'h0003;
        B = 16'h0005;
        for (int c = 0; c < 10; c++) begin
            tick();
            tests++;
            if (out_valid !== 1'b1 || Y !== 32'hFFFE0001 || busy !== 1'b1 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got v=%b y=%h busy=%b rdy=%b expected v=1 y=fffe0001 busy=1 rdy=0", c, out_valid, Y, busy, in_ready);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: got v=%b busy=%b rdy=%b expected v=0 busy=0 rdy=1", out_valid, busy, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        out_ready = 1'b1;
        A = 16'h1234;
        B = 16'h5678;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before_reset: got %b expected 1", busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        tests++;
        if (Y !== 32'h0 || out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_state: got y=%h v=%b rdy=%b busy=%b expected y=0 v=0 rdy=1 busy=0", Y, out_valid, in_ready, busy);
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_valid) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL mid_stale_result: got %0d valid cycles expected 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] pa [3] = '{16'h1111, 16'hBEEF, 16'h7FFF};
        logic [15:0] pb [3] = '{16'h2222, 16'hCAFE, 16'h8001};
        int acc_t [3];
        int nacc = 0;
        int nout = 0;
        logic take;
        out_ready = 1'b1;
        A = pa[0];
        B = pb[0];
        in_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            take = in_valid && in_ready;
            tick();
            if (take) begin
                acc_t[nacc] = t;
                nacc++;
                if (nacc < 3) begin
                    A = pa[nacc];
                    B = pb[nacc];
                end else in_valid = 1'b0;
            end
            if (out_valid) begin
                if (nout < 3) begin
                    tests++;
                    if (Y !== {16'd0, pa[nout]} * {16'd0, pb[nout]}) begin
                        fails++;
                        $display("FAIL b2b_y[%0d]: got %h expected %h", nout, Y, {16'd0, pa[nout]} * {16'd0, pb[nout]});
                    end
                end
                nout++;
            end
        end
        tests++; if (nacc !== 3) begin fails++; $display("FAIL b2b_accepts: got %0d expected 3", nacc); end
        tests++; if (nout !== 3) begin fails++; $display("FAIL b2b_results: got %0d expected 3", nout); end
        if (nacc == 3) begin
            tests++; if (acc_t[1] - acc_t[0] !== 6) begin fails++; $display("FAIL b2b_gap0: got %0d expected 6", acc_t[1] - acc_t[0]); end
            tests++; if (acc_t[2] - acc_t[1] !== 6) begin fails++; $display("FAIL b2b_gap1: got %0d expected 6", acc_t[2] - acc_t[1]); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        A = '0;
        B = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
